muldiv_sequencer: RTL

Multi-cycle controller and datapath for the DLX multiply/divide group: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Sits beside the single-cycle EX-stage ALU and receives the same 6-bit funct/ALU-control code the ALU decoder produces.
- Runs iterative shift-add multiply or restoring divide over WIDTH cycles.
- Raises a stall to the pipeline while busy and owns the architectural HI/LO registers.

---
 rtl/dlx_pkg.sv | 48 ++++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: ALU funct codes, multiply/divide group codes and
// the multi-cycle sequencer state/op encodings.
package dlx_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] FUNCT_SLL   = 6'h04;
  localparam logic [5:0] FUNCT_SRL   = 6'h06;
  localparam logic [5:0] FUNCT_SRA   = 6'h07;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_SLT   = 6'h2a;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2b;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_t;

  // Encoding matches funct[1:0] of the MULT..DIVU group: bit1 = divide, bit0 = unsigned.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f >= FUNCT_MULT) && (f <= FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide step
// on a 2*WIDTH accumulator {upper, lower}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_nx
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;

  always_comb begin
    // Multiply: lower half holds the remaining multiplier bits; the carry of
    // the add is shifted back into the top of the accumulator.
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    // Divide: partial remainder shifted left with the next dividend bit.
    trial = acc[2*WIDTH-1:WIDTH-1];
    diff  = trial - {1'b0, opnd};
    ge    = (trial >= {1'b0, opnd});
    acc_nx = '0;
    if (is_div) begin
      acc_nx = {(ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    end else if (acc[0]) begin
      acc_nx = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_nx = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with MTHI/MTLO; owns HI/LO and
// stalls the pipeline while an iterative operation is in flight.
module muldiv_sequencer
  import dlx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t state, state_nx;
  md_op_t    op;

  logic [WIDTH-1:0]   a_l, b_l, opnd;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix, abs_a, abs_b;
  logic [CNT_W-1:0]   cnt;
  logic               res_neg, rem_neg;
  logic               op_div, op_signed, div_by_zero, last_iter;

  assign op_div      = op[1];
  assign op_signed   = ~op[0];
  assign div_by_zero = op_div && (b_l == '0);
  assign last_iter   = (cnt == CNT_W'(WIDTH - 1));

  assign abs_a = (op_signed && a_l[WIDTH-1]) ? -a_l : a_l;
  assign abs_b = (op_signed && b_l[WIDTH-1]) ? -b_l : b_l;

  assign prod_fix = res_neg ? -acc : acc;
  assign q_fix    = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc),
    .opnd   (opnd),
    .is_div (op_div),
    .acc_nx (acc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !flush && is_muldiv(funct)) state_nx = ST_PREP;
      end
      ST_PREP: begin
        busy = 1'b1;
        if (flush)            state_nx = ST_IDLE;
        else if (div_by_zero) state_nx = ST_DONE;
        else                  state_nx = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (flush)          state_nx = ST_IDLE;
        else if (last_iter) state_nx = ST_FIX;
      end
      ST_FIX: begin
        busy = 1'b1;
        state_nx = flush ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign stall = busy;

  // Every architectural write is gated by flush so an aborted op leaves HI/LO intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi      <= '0;
      lo      <= '0;
      div0    <= 1'b0;
      a_l     <= '0;
      b_l     <= '0;
      op      <= OP_MULT;
      opnd    <= '0;
      acc     <= '0;
      cnt     <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
    end else if (!flush) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (funct == FUNCT_MTHI) hi <= a;
            if (funct == FUNCT_MTLO) lo <= a;
            if (is_muldiv(funct)) begin
              a_l  <= a;
              b_l  <= b;
              op   <= md_op_t'(funct[1:0]);
              div0 <= 1'b0;
            end
          end
        end
        ST_PREP: begin
          acc     <= {{WIDTH{1'b0}}, abs_a};
          opnd    <= abs_b;
          cnt     <= '0;
          res_neg <= op_signed & (a_l[WIDTH-1] ^ b_l[WIDTH-1]);
          rem_neg <= op_signed & a_l[WIDTH-1];
          if (div_by_zero) begin
            div0 <= 1'b1;
            hi   <= a_l;
            lo   <= '1;
          end
        end
        ST_CALC: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
        end
        ST_FIX: begin
          if (op_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
